// File: rtl/rdma_arb_cmd_user_if.sv
// Bundle of the request/data handshake signals around rdma_arb_cmd_user.
//   s_req_*  : two command streams (bit/slice i = source i)
//   s_axis_* : two data streams matching those commands
//   m_req_*  : merged command stream toward user logic
//   m_axis_* : merged data stream toward user logic
// Modports:
//   slave  - the arbiter's view (consumes s_*, produces m_*)
//   master - the environment's view (produces s_*, consumes m_*)
interface rdma_arb_cmd_user_if #(
  parameter int DATA_BITS = 512,
  parameter int LEN_BITS  = 28,
  parameter int PID_BITS  = 6,
  parameter int DEST_BITS = 4
);
  localparam int BYTES    = DATA_BITS / 8;
  localparam int REQ_BITS = 1 + PID_BITS + DEST_BITS + LEN_BITS;

  logic [1:0]            s_req_valid;
  logic [1:0]            s_req_ready;
  logic [2*REQ_BITS-1:0] s_req_data;

  logic [1:0]             s_axis_tvalid;
  logic [1:0]             s_axis_tready;
  logic [2*DATA_BITS-1:0] s_axis_tdata;
  logic [2*BYTES-1:0]     s_axis_tkeep;
  logic [2*PID_BITS-1:0]  s_axis_tid;
  logic [1:0]             s_axis_tlast;

  logic                m_req_valid;
  logic                m_req_ready;
  logic [REQ_BITS-1:0] m_req_data;

  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [DATA_BITS-1:0] m_axis_tdata;
  logic [BYTES-1:0]     m_axis_tkeep;
  logic [PID_BITS-1:0]  m_axis_tid;
  logic                 m_axis_tlast;

  modport slave (
    input  s_req_valid, s_req_data,
    output s_req_ready,
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tid, s_axis_tlast,
    output s_axis_tready,
    output m_req_valid, m_req_data,
    input  m_req_ready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_req_valid, s_req_data,
    input  s_req_ready,
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tid, s_axis_tlast,
    input  s_axis_tready,
    input  m_req_valid, m_req_data,
    output m_req_ready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/rdma_arb_cmd_user.sv
// Merges two command/data stream pairs into one user-facing write port.
// Source 0 = local host completion path, source 1 = RDMA read-response path.
// A round-robin arbiter forwards commands through a one-deep output register
// and records {source, beat count} in an in-order sequence queue; the data
// FSM then forwards exactly that many beats from that source.
// Ports:
//   aclk     clock
//   aresetn  async active-low reset
//   bus      rdma_arb_cmd_user_if.slave (s_req/s_axis in, m_req/m_axis out)
//
// State table:
//   ST_IDLE | no packet in progress; pops the queue head when available
//   ST_MUX  | forwarding beats of source src_c until nb_c beats are done
module rdma_arb_cmd_user #(
  parameter int DATA_BITS     = 512,
  parameter int LEN_BITS      = 28,
  parameter int PID_BITS      = 6,
  parameter int DEST_BITS     = 4,
  parameter int N_OUTSTANDING = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  rdma_arb_cmd_user_if.slave   bus
);
  localparam int BYTES    = DATA_BITS / 8;
  localparam int BLOG     = $clog2(BYTES);
  localparam int REQ_BITS = 1 + PID_BITS + DEST_BITS + LEN_BITS;
  localparam int NB_BITS  = LEN_BITS - BLOG + 1;
  localparam int LW1      = LEN_BITS + 1;
  localparam int QLOG     = $clog2(N_OUTSTANDING);

  typedef enum logic {ST_IDLE, ST_MUX} state_t;

  state_t              state;
  logic                src_c;
  logic [NB_BITS-1:0]  nb_c;
  logic [NB_BITS-1:0]  cnt_c;

  logic                rr_pri;
  logic                req_valid_q;
  logic [REQ_BITS-1:0] req_data_q;

  logic [QLOG:0]       wr_ptr;
  logic [QLOG:0]       rd_ptr;
  logic [NB_BITS:0]    q_mem [N_OUTSTANDING];
  logic [NB_BITS:0]    q_head;
  logic                q_empty;
  logic                q_full;

  logic                can_grant;
  logic                gnt;
  logic                gnt_src;
  logic [REQ_BITS-1:0] req_g;
  logic [LEN_BITS-1:0] len_g;
  logic [LEN_BITS:0]   len_rnd;
  logic [NB_BITS-1:0]  nb_g;
  logic                push;
  logic                pop;
  logic                mux_valid;
  logic                beat_hs;
  logic                last_beat;
  logic [1:0]          unused_bits;

  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[QLOG] != rd_ptr[QLOG]) &&
                   (wr_ptr[QLOG-1:0] == rd_ptr[QLOG-1:0]);
  assign q_head  = q_mem[rd_ptr[QLOG-1:0]];

  // Ready is held low while reset is asserted so nothing is accepted then.
  always_comb begin
    can_grant = aresetn && (!req_valid_q || bus.m_req_ready) && !q_full;
    if (bus.s_req_valid == 2'b11) gnt_src = rr_pri;
    else                          gnt_src = bus.s_req_valid[1];
    gnt = can_grant && (bus.s_req_valid != 2'b00);
  end

  assign req_g   = gnt_src ? bus.s_req_data[REQ_BITS +: REQ_BITS]
                           : bus.s_req_data[0 +: REQ_BITS];
  assign len_g   = req_g[LEN_BITS-1:0];
  assign len_rnd = {1'b0, len_g} + LW1'(BYTES - 1);
  assign nb_g    = len_rnd[LEN_BITS:BLOG];
  // Zero-length commands carry no data, so they never enter the queue.
  assign push    = gnt && (len_g != '0);

  assign bus.s_req_ready = {gnt && gnt_src, gnt && !gnt_src};
  assign bus.m_req_valid = req_valid_q;
  assign bus.m_req_data  = req_data_q;

  assign mux_valid = bus.s_axis_tvalid[src_c];
  assign beat_hs   = (state == ST_MUX) && mux_valid && bus.m_axis_tready;
  assign last_beat = (cnt_c == nb_c - NB_BITS'(1));
  // Popping on the last beat lets the next packet start with no bubble.
  assign pop       = !q_empty && ((state == ST_IDLE) || (beat_hs && last_beat));

  assign bus.m_axis_tvalid = (state == ST_MUX) && mux_valid;
  assign bus.m_axis_tdata  = src_c ? bus.s_axis_tdata[DATA_BITS +: DATA_BITS]
                                   : bus.s_axis_tdata[0 +: DATA_BITS];
  assign bus.m_axis_tkeep  = src_c ? bus.s_axis_tkeep[BYTES +: BYTES]
                                   : bus.s_axis_tkeep[0 +: BYTES];
  assign bus.m_axis_tid    = src_c ? bus.s_axis_tid[PID_BITS +: PID_BITS]
                                   : bus.s_axis_tid[0 +: PID_BITS];
  assign bus.m_axis_tlast  = (state == ST_MUX) && last_beat;
  assign bus.s_axis_tready = (state != ST_MUX) ? 2'b00 :
                             (src_c ? {bus.m_axis_tready, 1'b0}
                                    : {1'b0, bus.m_axis_tready});

  // Framing comes from the command length, not from upstream tlast.
  assign unused_bits = {^bus.s_axis_tlast, ^len_rnd[BLOG-1:0]};

  always_ff @(posedge aclk) begin
    if (push) q_mem[wr_ptr[QLOG-1:0]] <= {gnt_src, nb_g};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_pri      <= 1'b0;
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      state       <= ST_IDLE;
      src_c       <= 1'b0;
      nb_c        <= '0;
      cnt_c       <= '0;
    end else begin
      if (gnt) begin
        req_valid_q <= 1'b1;
        req_data_q  <= req_g;
        rr_pri      <= ~gnt_src;
      end else if (bus.m_req_ready) begin
        req_valid_q <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case (state)
        ST_IDLE: begin
          if (pop) begin
            src_c <= q_head[NB_BITS];
            nb_c  <= q_head[NB_BITS-1:0];
            cnt_c <= '0;
            state <= ST_MUX;
          end
        end
        ST_MUX: begin
          if (beat_hs) begin
            if (last_beat) begin
              cnt_c <= '0;
              if (pop) begin
                src_c <= q_head[NB_BITS];
                nb_c  <= q_head[NB_BITS-1:0];
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              cnt_c <= cnt_c + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
